// File: rtl/lcd_dual_view_proc.sv
// Dual-window LCD pixel source: one ROM image shown raw on the left and processed on the right.
// Addresses are issued ahead of the scan so ROM data and the gray stage line up with the output register.
module lcd_dual_view_proc #(
  parameter int          IMG_W    = 250,
  parameter int          IMG_H    = 250,
  parameter int          ADDR_W   = 16,
  parameter int          X0_RAW   = 2,
  parameter int          X0_PROC  = 302,
  parameter int          Y0       = 0,
  parameter int          ROM_LAT  = 1,
  parameter logic [23:0] BG_COLOR = 24'hFFFFFF
) (
  input  logic              lcd_pclk,
  input  logic              rst_n,
  input  logic [10:0]       pixel_xpos,
  input  logic [10:0]       pixel_ypos,
  input  logic [10:0]       h_disp,
  input  logic [10:0]       v_disp,
  input  logic [1:0]        mode_sel,
  input  logic [7:0]        thresh,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [23:0]       rom_rd_data,
  output logic [1:0]        frame_mode,
  output logic [23:0]       pixel_data
);

  localparam int LAT_RAW  = ROM_LAT + 1;
  localparam int LAT_PROC = ROM_LAT + 2;
  localparam int DEPTH    = ROM_LAT + 2;

  typedef struct packed {
    logic hit_raw;
    logic hit_proc;
    logic clip;
  } tag_t;

  int                x_i;
  int                y_i;
  int                hd_i;
  int                vd_i;
  int                row;
  int                col_raw;
  int                col_proc;
  logic              row_ok;
  logic              fetch_raw;
  logic              fetch_proc;
  logic              clip_raw;
  logic              clip_proc;
  logic              at_origin;
  logic [ADDR_W-1:0] addr_next;
  tag_t              tag_new;
  tag_t              tag_pipe [DEPTH];
  logic [7:0]        gray_q;
  logic [7:0]        inv_gray;
  logic [7:0]        thr_q;
  logic [23:0]       rgb_q;
  logic [23:0]       pixel_next;

  // Lookahead fetch: the column is the one that will be on screen LAT clocks from now.
  always_comb begin
    x_i        = int'(pixel_xpos);
    y_i        = int'(pixel_ypos);
    hd_i       = int'(h_disp);
    vd_i       = int'(v_disp);
    row        = y_i - Y0;
    col_raw    = x_i + LAT_RAW - X0_RAW;
    col_proc   = x_i + LAT_PROC - X0_PROC;
    row_ok     = (row >= 0) && (row < IMG_H);
    fetch_raw  = row_ok && (col_raw >= 0) && (col_raw < IMG_W);
    fetch_proc = row_ok && (col_proc >= 0) && (col_proc < IMG_W);
    clip_raw   = (x_i + LAT_RAW >= hd_i) || (y_i >= vd_i);
    clip_proc  = (x_i + LAT_PROC >= hd_i) || (y_i >= vd_i);
    at_origin  = (pixel_xpos == 11'd0) && (pixel_ypos == 11'd0);

    tag_new          = '0;
    tag_new.hit_raw  = fetch_raw;
    tag_new.hit_proc = fetch_proc;
    tag_new.clip     = fetch_raw ? clip_raw : clip_proc;

    addr_next = rom_addr;
    if (fetch_raw) begin
      addr_next = ADDR_W'(row * IMG_W + col_raw);
    end else if (fetch_proc) begin
      addr_next = ADDR_W'(row * IMG_W + col_proc);
    end
  end

  always_ff @(posedge lcd_pclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        tag_pipe[i] <= '0;
      end
    end else begin
      tag_pipe[0] <= tag_new;
      for (int i = 1; i < DEPTH; i++) begin
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  // Raw pixels use the tag ROM_LAT+1 clocks old; processed pixels one clock older for the gray stage.
  always_comb begin
    inv_gray   = 8'd255 - gray_q;
    pixel_next = BG_COLOR;
    if (tag_pipe[ROM_LAT].hit_raw && !tag_pipe[ROM_LAT].clip) begin
      pixel_next = rom_rd_data;
    end else if (tag_pipe[DEPTH-1].hit_proc && !tag_pipe[DEPTH-1].clip) begin
      case (frame_mode)
        2'd0:    pixel_next = {3{gray_q}};
        2'd1:    pixel_next = {3{inv_gray}};
        2'd2:    pixel_next = (gray_q >= thr_q) ? 24'hFFFFFF : 24'h000000;
        default: pixel_next = rgb_q;
      endcase
    end
  end

  always_ff @(posedge lcd_pclk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr   <= '0;
      frame_mode <= 2'd0;
      thr_q      <= 8'd128;
      gray_q     <= 8'd0;
      rgb_q      <= 24'd0;
      pixel_data <= BG_COLOR;
    end else begin
      rom_addr   <= addr_next;
      gray_q     <= 8'((16'd76  * {8'd0, rom_rd_data[23:16]}
                      + 16'd150 * {8'd0, rom_rd_data[15:8]}
                      + 16'd29  * {8'd0, rom_rd_data[7:0]}) >> 8);
      rgb_q      <= rom_rd_data;
      pixel_data <= pixel_next;
      if (at_origin) begin
        frame_mode <= mode_sel;
        thr_q      <= thresh;
      end
    end
  end

endmodule

// File: tb/tb_lcd_dual_view_proc.sv
// Bench for lcd_dual_view_proc: three instances (ROM latency 1, 2, 3) scanned together
// against a per-pixel window model evaluated at the output position.
module tb_lcd_dual_view_proc;

  localparam int          W    = 250;
  localparam int          H    = 250;
  localparam int          X0P  = 302;
  localparam int          XMAX = 559;
  localparam logic [23:0] BG   = 24'hFFFFFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] xpos, ypos, h_disp, v_disp;
  logic [1:0]  mode_sel;
  logic [7:0]  thresh;
  logic [15:0] addr1, addr2, addr3;
  logic [23:0] rd1, rd2, rd3, pix1, pix2, pix3;
  logic [1:0]  fm1, fm2, fm3;

  logic [23:0] mem [W*H];
  logic [23:0] p1, p2a, p2b, p3a, p3b, p3c;
  logic [23:0] got [3][XMAX+1];
  logic [23:0] pix_v [3];
  logic [15:0] addr_v [3];
  logic [1:0]  fm_v [3];
  int          x0r [3] = '{2, 3, 4};
  int          lat_mode, lat_thr;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  lcd_dual_view_proc #(.ROM_LAT(1), .X0_RAW(2)) d1 (
    .lcd_pclk(clk), .rst_n(rst_n), .pixel_xpos(xpos), .pixel_ypos(ypos),
    .h_disp(h_disp), .v_disp(v_disp), .mode_sel(mode_sel), .thresh(thresh),
    .rom_addr(addr1), .rom_rd_data(rd1), .frame_mode(fm1), .pixel_data(pix1));
  lcd_dual_view_proc #(.ROM_LAT(2), .X0_RAW(3)) d2 (
    .lcd_pclk(clk), .rst_n(rst_n), .pixel_xpos(xpos), .pixel_ypos(ypos),
    .h_disp(h_disp), .v_disp(v_disp), .mode_sel(mode_sel), .thresh(thresh),
    .rom_addr(addr2), .rom_rd_data(rd2), .frame_mode(fm2), .pixel_data(pix2));
  lcd_dual_view_proc #(.ROM_LAT(3), .X0_RAW(4)) d3 (
    .lcd_pclk(clk), .rst_n(rst_n), .pixel_xpos(xpos), .pixel_ypos(ypos),
    .h_disp(h_disp), .v_disp(v_disp), .mode_sel(mode_sel), .thresh(thresh),
    .rom_addr(addr3), .rom_rd_data(rd3), .frame_mode(fm3), .pixel_data(pix3));

  // Synchronous ROMs with 1, 2 and 3 clocks of read latency
  always @(posedge clk) begin
    p1  <= mem[addr1];
    p2a <= mem[addr2];
    p2b <= p2a;
    p3a <= mem[addr3];
    p3b <= p3a;
    p3c <= p3b;
  end
  assign rd1 = p1;
  assign rd2 = p2b;
  assign rd3 = p3c;

  always_comb begin
    pix_v[0]  = pix1;  pix_v[1]  = pix2;  pix_v[2]  = pix3;
    addr_v[0] = addr1; addr_v[1] = addr2; addr_v[2] = addr3;
    fm_v[0]   = fm1;   fm_v[1]   = fm2;   fm_v[2]   = fm3;
  end

  function automatic logic [23:0] model_pix(int k, int x, int y);
    logic [23:0] w;
    int          g;
    if (x >= int'(h_disp) || y >= int'(v_disp) || y >= H) return BG;
    if (x >= x0r[k] && x < x0r[k] + W) return mem[y*W + x - x0r[k]];
    if (x < X0P || x >= X0P + W) return BG;
    w = mem[y*W + x - X0P];
    g = (76 * int'(w[23:16]) + 150 * int'(w[15:8]) + 29 * int'(w[7:0])) / 256;
    case (lat_mode)
      0:       return {3{8'(g)}};
      1:       return {3{8'(255 - g)}};
      2:       return (g >= lat_thr) ? 24'hFFFFFF : 24'h000000;
      default: return w;
    endcase
  endfunction

  task automatic fill_row(input int r);
    for (int c = 0; c < W; c++) mem[r*W + c] = 24'($urandom);
  endtask

  // Present x=0..XMAX on line y; got[k][x] holds each DUT's pixel for x.
  task automatic scan_line(input int y);
    for (int x = 0; x <= XMAX; x++) begin
      @(negedge clk);
      if (x > 0) for (int k = 0; k < 3; k++) got[k][x-1] = pix_v[k];
      xpos = 11'(x);
      ypos = 11'(y);
      if (x == 0 && y == 0) begin
        lat_mode = int'(mode_sel);
        lat_thr  = int'(thresh);
      end
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) got[k][XMAX] = pix_v[k];
    xpos = 11'd2047;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    xpos  = 11'd2047;
    ypos  = 11'd2047;
    repeat (5) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (pix_v[k] !== BG) begin errors++; $display("FAIL reset_pixel dut%0d got=%06h exp=%06h", k, pix_v[k], BG); end
      checks++;
      if (addr_v[k] !== 16'd0) begin errors++; $display("FAIL reset_addr dut%0d got=%0d exp=0", k, addr_v[k]); end
      checks++;
      if (fm_v[k] !== 2'd0) begin errors++; $display("FAIL reset_mode dut%0d got=%0d exp=0", k, fm_v[k]); end
    end
    rst_n    = 1'b1;
    lat_mode = 0;
    lat_thr  = 128;
  endtask

  task automatic test_raw_align;
    logic [23:0] e;
    mode_sel = 2'd0;
    scan_line(0);
    scan_line(3);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (got[k][x0r[k]+5] !== 24'd755) begin errors++; $display("FAIL raw_align dut%0d got=%06h exp=%06h", k, got[k][x0r[k]+5], 24'd755); end
      checks++;
      if (got[k][x0r[k]-1] !== BG) begin errors++; $display("FAIL raw_left_edge dut%0d got=%06h exp=%06h", k, got[k][x0r[k]-1], BG); end
      checks++;
      if (got[k][x0r[k]+W] !== BG) begin errors++; $display("FAIL raw_right_edge dut%0d got=%06h exp=%06h", k, got[k][x0r[k]+W], BG); end
      checks++;
      if (addr_v[k] !== 16'(3*W + 249)) begin errors++; $display("FAIL line_end_addr dut%0d got=%0d exp=%0d", k, addr_v[k], 3*W + 249); end
      for (int x = 0; x <= XMAX; x++) begin
        e = model_pix(k, x, 3); checks++;
        if (got[k][x] !== e) begin errors++; $display("FAIL raw_line dut%0d x=%0d got=%06h exp=%06h", k, x, got[k][x], e); end
      end
    end
  endtask

  task automatic test_gray;
    logic [23:0] e;
    for (int c = 0; c < W; c++) mem[5*W + c] = (c < 125) ? 24'hFF0000 : 24'hFFFFFF;
    mode_sel = 2'd0;
    scan_line(0);
    scan_line(5);
    for (int k = 0; k < 3; k++) begin
      // 76*255 >> 8 = 75
      checks++;
      if (got[k][X0P] !== 24'h4B4B4B) begin errors++; $display("FAIL gray_red dut%0d got=%06h exp=4b4b4b", k, got[k][X0P]); end
      checks++;
      if (got[k][X0P+200] !== 24'hFEFEFE) begin errors++; $display("FAIL gray_white dut%0d got=%06h exp=fefefe", k, got[k][X0P+200]); end
      for (int x = 0; x <= XMAX; x++) begin
        e = model_pix(k, x, 5); checks++;
        if (got[k][x] !== e) begin errors++; $display("FAIL gray_line dut%0d x=%0d got=%06h exp=%06h", k, x, got[k][x], e); end
      end
    end
    mode_sel = 2'd1;
    scan_line(0);
    scan_line(5);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (got[k][X0P] !== 24'hB4B4B4) begin errors++; $display("FAIL inv_gray_red dut%0d got=%06h exp=b4b4b4", k, got[k][X0P]); end
      for (int x = 0; x <= XMAX; x++) begin
        e = model_pix(k, x, 5); checks++;
        if (got[k][x] !== e) begin errors++; $display("FAIL inv_gray_line dut%0d x=%0d got=%06h exp=%06h", k, x, got[k][x], e); end
      end
    end
  endtask

  task automatic test_threshold;
    logic [23:0] e;
    fill_row(7);
    mem[7*W + 0] = 24'h646464;  // g = 99
    mem[7*W + 1] = 24'h656565;  // g = 100
    mode_sel = 2'd2;
    thresh   = 8'd100;
    scan_line(0);
    scan_line(7);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (got[k][X0P] !== 24'h000000) begin errors++; $display("FAIL thresh_below dut%0d got=%06h exp=000000", k, got[k][X0P]); end
      checks++;
      if (got[k][X0P+1] !== 24'hFFFFFF) begin errors++; $display("FAIL thresh_equal dut%0d got=%06h exp=ffffff", k, got[k][X0P+1]); end
      for (int x = 0; x <= XMAX; x++) begin
        e = model_pix(k, x, 7); checks++;
        if (got[k][x] !== e) begin errors++; $display("FAIL thresh_line dut%0d x=%0d got=%06h exp=%06h", k, x, got[k][x], e); end
      end
    end
  endtask

  task automatic test_mode_latch;
    logic [23:0] e;
    fill_row(10);
    fill_row(11);
    mode_sel = 2'd0;
    scan_line(0);
    mode_sel = 2'd3;
    scan_line(10);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (fm_v[k] !== 2'd0) begin errors++; $display("FAIL latch_hold dut%0d got=%0d exp=0", k, fm_v[k]); end
      for (int x = 0; x <= XMAX; x++) begin
        e = model_pix(k, x, 10); checks++;
        if (got[k][x] !== e) begin errors++; $display("FAIL latch_old_line dut%0d x=%0d got=%06h exp=%06h", k, x, got[k][x], e); end
      end
    end
    scan_line(0);
    scan_line(11);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (fm_v[k] !== 2'd3) begin errors++; $display("FAIL latch_new dut%0d got=%0d exp=3", k, fm_v[k]); end
      checks++;
      if (got[k][X0P+7] !== mem[11*W + 7]) begin errors++; $display("FAIL passthrough dut%0d got=%06h exp=%06h", k, got[k][X0P+7], mem[11*W + 7]); end
      for (int x = 0; x <= XMAX; x++) begin
        e = model_pix(k, x, 11); checks++;
        if (got[k][x] !== e) begin errors++; $display("FAIL latch_new_line dut%0d x=%0d got=%06h exp=%06h", k, x, got[k][x], e); end
      end
    end
  endtask

  task automatic test_clip;
    logic [23:0] e;
    fill_row(20);
    h_disp   = 11'd400;
    mode_sel = 2'($urandom_range(0, 3));
    thresh   = 8'($urandom);
    scan_line(0);
    scan_line(20);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (got[k][400] !== BG) begin errors++; $display("FAIL hclip_edge dut%0d got=%06h exp=%06h", k, got[k][400], BG); end
      for (int x = 0; x <= XMAX; x++) begin
        e = model_pix(k, x, 20); checks++;
        if (got[k][x] !== e) begin errors++; $display("FAIL hclip_line dut%0d x=%0d got=%06h exp=%06h", k, x, got[k][x], e); end
      end
    end
    h_disp = 11'd800;
    v_disp = 11'd20;
    scan_line(20);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (got[k][x0r[k]+10] !== BG) begin errors++; $display("FAIL vclip_raw dut%0d got=%06h exp=%06h", k, got[k][x0r[k]+10], BG); end
      checks++;
      if (got[k][X0P+10] !== BG) begin errors++; $display("FAIL vclip_proc dut%0d got=%06h exp=%06h", k, got[k][X0P+10], BG); end
    end
    v_disp = 11'd21;
    scan_line(20);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (got[k][x0r[k]+10] !== mem[20*W + 10]) begin errors++; $display("FAIL vclip_last_line dut%0d got=%06h exp=%06h", k, got[k][x0r[k]+10], mem[20*W + 10]); end
    end
    v_disp = 11'd480;
  endtask

  task automatic test_back_to_back;
    logic [23:0] e;
    fill_row(30);
    fill_row(31);
    mode_sel = 2'($urandom_range(0, 3));
    thresh   = 8'($urandom);
    scan_line(0);
    for (int r = 30; r <= 31; r++) begin
      scan_line(r);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (addr_v[k] !== 16'(r*W + 249)) begin errors++; $display("FAIL b2b_end_addr dut%0d got=%0d exp=%0d", k, addr_v[k], r*W + 249); end
        for (int x = 0; x <= XMAX; x++) begin
          e = model_pix(k, x, r); checks++;
          if (got[k][x] !== e) begin errors++; $display("FAIL b2b_line dut%0d y=%0d x=%0d got=%06h exp=%06h", k, r, x, got[k][x], e); end
        end
      end
    end
  endtask

  task automatic test_random;
    logic [23:0] e;
    int          r;
    for (int it = 0; it < 4; it++) begin
      r        = int'($urandom_range(0, 259));
      mode_sel = 2'($urandom_range(0, 3));
      thresh   = 8'($urandom);
      h_disp   = 11'($urandom_range(300, 800));
      v_disp   = 11'($urandom_range(200, 480));
      if (r < H) fill_row(r);
      scan_line(0);
      scan_line(r);
      for (int k = 0; k < 3; k++) begin
        for (int x = 0; x <= XMAX; x++) begin
          e = model_pix(k, x, r); checks++;
          if (got[k][x] !== e) begin errors++; $display("FAIL random_line dut%0d y=%0d x=%0d got=%06h exp=%06h", k, r, x, got[k][x], e); end
        end
      end
    end
    h_disp = 11'd800;
    v_disp = 11'd480;
  endtask

  task automatic test_midframe_reset;
    logic [23:0] e;
    fill_row(5);
    mode_sel = 2'd3;
    scan_line(0);
    for (int x = 0; x <= 350; x++) begin
      @(negedge clk);
      xpos = 11'(x);
      ypos = 11'd5;
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (pix_v[k] !== BG) begin errors++; $display("FAIL midreset_pixel dut%0d got=%06h exp=%06h", k, pix_v[k], BG); end
      checks++;
      if (addr_v[k] !== 16'd0) begin errors++; $display("FAIL midreset_addr dut%0d got=%0d exp=0", k, addr_v[k]); end
      checks++;
      if (fm_v[k] !== 2'd0) begin errors++; $display("FAIL midreset_mode dut%0d got=%0d exp=0", k, fm_v[k]); end
    end
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    lat_mode = 0;
    lat_thr  = 128;
    mode_sel = 2'd1;
    scan_line(0);
    scan_line(5);
    for (int k = 0; k < 3; k++) begin
      for (int x = 0; x <= XMAX; x++) begin
        e = model_pix(k, x, 5); checks++;
        if (got[k][x] !== e) begin errors++; $display("FAIL post_reset_line dut%0d x=%0d got=%06h exp=%06h", k, x, got[k][x], e); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < W*H; i++) mem[i] = 24'(i);
    h_disp   = 11'd800;
    v_disp   = 11'd480;
    mode_sel = 2'd0;
    thresh   = 8'd0;
    test_reset;
    test_raw_align;
    test_gray;
    test_threshold;
    test_mode_latch;
    test_clip;
    test_back_to_back;
    test_random;
    test_midframe_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
